// File: rtl/rng_pkg.sv
// Shared definitions for the multi-channel LFSR random number generator:
// the LFSR geometry, channel seed salt, FSM encoding and the step/select/seed helpers.
package rng_pkg;

   localparam int          LFSR_W = 32;
   localparam int          TAP_A  = 31;
   localparam int          TAP_B  = 21;
   localparam int          TAP_C  = 1;
   localparam int          TAP_D  = 0;
   localparam logic [31:0] SALT   = 32'h9E37_79B9;

   typedef enum logic [1:0] {
      UNSEEDED = 2'd0,
      WARMUP   = 2'd1,
      RUN      = 2'd2
   } rng_state_e;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D], s[LFSR_W-1:1]};
   endfunction

   // The 8- and 16-bit picks keep the legacy RNG bit selections; the result is zero-extended.
   function automatic logic [LFSR_W-1:0] out_select(input logic [LFSR_W-1:0] s, input int out_w);
      logic [LFSR_W-1:0] r;
      case (out_w)
         8:       r = {24'h00_0000, s[31:30], s[21:20], s[3:0]};
         16:      r = {16'h0000, s[31:21], s[4:0]};
         default: r = s;
      endcase
      return r;
   endfunction

   function automatic logic [LFSR_W-1:0] ch_seed(input logic [LFSR_W-1:0] base, input int k);
      logic [LFSR_W-1:0] pair_idx;
      logic [LFSR_W-1:0] salt_mul;
      pair_idx = 32'(k >> 1);
      salt_mul = SALT * pair_idx;
      return ((k % 2) != 0 ? ~base : base) ^ salt_mul;
   endfunction

endpackage

// File: rtl/rng_lfsr_ch.sv
// One LFSR channel: derives its seed from the shared base word, loads or steps on command.
// With RNG_LOCKUP_GUARD_EN defined an all-zero derived seed is replaced by 1 and flagged.
module rng_lfsr_ch
   import rng_pkg::*;
#(
   parameter int          K          = 0,
   parameter logic [31:0] RESET_SEED = 32'hACE1_ACE1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [LFSR_W-1:0] base,
   output logic [LFSR_W-1:0] state
`ifdef RNG_LOCKUP_GUARD_EN
   ,
   output logic              seed_zero
`endif
);

   localparam logic [LFSR_W-1:0] RST_DERIVED = ch_seed(RESET_SEED, K);

   logic [LFSR_W-1:0] derived_s;
   logic [LFSR_W-1:0] load_val_s;
   logic [LFSR_W-1:0] state_r;

   assign derived_s = ch_seed(base, K);

`ifdef RNG_LOCKUP_GUARD_EN
   localparam logic [LFSR_W-1:0] RST_VAL = (RST_DERIVED == 32'h0000_0000) ? 32'h0000_0001 : RST_DERIVED;
   assign seed_zero  = (derived_s == 32'h0000_0000);
   assign load_val_s = seed_zero ? 32'h0000_0001 : derived_s;
`else
   localparam logic [LFSR_W-1:0] RST_VAL = RST_DERIVED;
   assign load_val_s = derived_s;
`endif

   // Channel state: a load takes priority over a step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= RST_VAL;
      end else if (load) begin
         state_r <= load_val_s;
      end else if (step) begin
         state_r <= lfsr_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/rng_multi.sv
// NUM_CH-channel LFSR random number generator with seed/output handshakes and warm-up discard.
// Optional feature macro: RNG_LOCKUP_GUARD_EN (zero-seed substitution and sticky lockup_err).
module rng_multi
   import rng_pkg::*;
#(
   parameter int          NUM_CH     = 2,
   parameter int          OUT_W      = 8,
   parameter int          WARMUP_CYC = 0,
   parameter logic [31:0] RESET_SEED = 32'hACE1_ACE1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             seed,
   input  logic                    seed_valid,
   output logic                    seed_ready,
   output logic [NUM_CH*OUT_W-1:0] rnd,
   output logic                    rnd_valid,
   input  logic                    rnd_ready,
   output logic                    lockup_err
);

   localparam bit                WARMUP_ON = (WARMUP_CYC > 0);
   localparam int                CNT_W     = WARMUP_ON ? $clog2(WARMUP_CYC + 1) : 1;
   localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP_ON ? WARMUP_CYC - 1 : 0);

   generate
      if (OUT_W != 8 && OUT_W != 16 && OUT_W != 32) begin : g_bad_out_w
         $error("rng_multi: OUT_W must be 8, 16 or 32");
      end
      if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
         $error("rng_multi: NUM_CH must be 1..16");
      end
      if (WARMUP_CYC < 0 || WARMUP_CYC > 65535) begin : g_bad_warmup
         $error("rng_multi: WARMUP_CYC must be 0..65535");
      end
   endgenerate

   rng_state_e        state_r;
   rng_state_e        state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_s;
   logic              warm_step_s;
   logic              load_s;
   logic              step_s;
   logic [LFSR_W-1:0] ch_state_s [NUM_CH];

   // Handshake flags decode straight from the state register so reset drops them at once.
   assign seed_ready = (state_r != WARMUP);
   assign rnd_valid  = (state_r == RUN);
   assign load_s     = seed_valid & seed_ready;
   assign step_s     = warm_step_s | (rnd_valid & rnd_ready & ~load_s);

   // FSM state and warm-up counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= UNSEEDED;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
      end
   end

   // Next-state logic; the counter is cleared on leaving warm-up, so it never wraps.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      warm_step_s = 1'b0;
      case (state_r)
         UNSEEDED, RUN: begin
            if (load_s) begin
               state_s = WARMUP_ON ? WARMUP : RUN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = state_r;
            end
         end
         WARMUP: begin
            warm_step_s = 1'b1;
            if (cnt_r == WARM_LAST) begin
               state_s = RUN;
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_s = UNSEEDED;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

`ifdef RNG_LOCKUP_GUARD_EN
   logic [NUM_CH-1:0] zero_s;
   logic              lockup_r;

   // Lockup flag is re-evaluated on every seed accept and otherwise held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lockup_r <= 1'b0;
      end else if (load_s) begin
         lockup_r <= |zero_s;
      end else begin
         lockup_r <= lockup_r;
      end
   end

   assign lockup_err = lockup_r;
`else
   assign lockup_err = 1'b0;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      rng_lfsr_ch #(
         .K          (k),
         .RESET_SEED (RESET_SEED)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .load      (load_s),
         .step      (step_s),
         .base      (seed),
         .state     (ch_state_s[k])
`ifdef RNG_LOCKUP_GUARD_EN
         ,
         .seed_zero (zero_s[k])
`endif
      );

      assign rnd[k*OUT_W +: OUT_W] = OUT_W'(out_select(ch_state_s[k], OUT_W));
   end

endmodule

// File: tb/tb_rng_multi.sv
// Self-checking bench for rng_multi: three instances (4ch/8b, 2ch/32b, 1ch/32b with warm-up)
// checked against an independent LFSR model through an expected-value queue.
module tb_rng_multi;

   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef RNG_LOCKUP_GUARD_EN
   localparam logic GUARD = 1'b1;
`else
   localparam logic GUARD = 1'b0;
`endif
   localparam logic [31:0] RST_SEED = 32'hACE1_ACE1;
   localparam int          DIST_N   = 24000;

   logic [31:0] a_seed, b_seed, c_seed;
   logic        a_seed_valid, b_seed_valid, c_seed_valid;
   logic        a_seed_ready, b_seed_ready, c_seed_ready;
   logic [31:0] a_rnd;
   logic [63:0] b_rnd;
   logic [31:0] c_rnd;
   logic        a_rnd_valid, b_rnd_valid, c_rnd_valid;
   logic        a_rnd_ready, b_rnd_ready, c_rnd_ready;
   logic        a_lockup, b_lockup, c_lockup;

   rng_multi #(.NUM_CH(4), .OUT_W(8), .WARMUP_CYC(0), .RESET_SEED(RST_SEED)) u_a (
      .clk(clk), .reset(reset), .seed(a_seed), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
      .rnd(a_rnd), .rnd_valid(a_rnd_valid), .rnd_ready(a_rnd_ready), .lockup_err(a_lockup));

   rng_multi #(.NUM_CH(2), .OUT_W(32), .WARMUP_CYC(0), .RESET_SEED(RST_SEED)) u_b (
      .clk(clk), .reset(reset), .seed(b_seed), .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
      .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready), .lockup_err(b_lockup));

   rng_multi #(.NUM_CH(1), .OUT_W(32), .WARMUP_CYC(3), .RESET_SEED(RST_SEED)) u_c (
      .clk(clk), .reset(reset), .seed(c_seed), .seed_valid(c_seed_valid), .seed_ready(c_seed_ready),
      .rnd(c_rnd), .rnd_valid(c_rnd_valid), .rnd_ready(c_rnd_ready), .lockup_err(c_lockup));

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] exp_q [$];
   string       tag_q [$];
   logic [31:0] ma [4];
   logic [31:0] mb [2];
   logic [31:0] mc;
   int          hist [10];
   int          bin_size [10];

   function automatic logic [31:0] m_step(input logic [31:0] s);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {fb, s[31:1]};
   endfunction

   function automatic logic [31:0] m_seed(input logic [31:0] b, input int k);
      logic [31:0] v;
      logic [31:0] half;
      half = 32'(k / 2);
      v = (k % 2 == 1) ? ~b : b;
      v = v ^ (32'h9E37_79B9 * half);
      if (GUARD && v == 32'h0) v = 32'h1;
      return v;
   endfunction

   function automatic logic [7:0] m_sel8(input logic [31:0] s);
      return {s[31], s[30], s[21], s[20], s[3], s[2], s[1], s[0]};
   endfunction

   function automatic logic [63:0] a_word();
      return {32'h0, m_sel8(ma[3]), m_sel8(ma[2]), m_sel8(ma[1]), m_sel8(ma[0])};
   endfunction

   function automatic logic [63:0] b_word();
      return {mb[1], mb[0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [63:0] e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic pop_cmp(input logic [63:0] obs);
      checks++;
      assert (exp_q.size() != 0)
      else begin
         failures++;
         $error("FAIL sb_underflow observed=%h expected=queued_entry", obs);
      end
      if (exp_q.size() != 0) begin
         checks--;
         chk(tag_q.pop_front(), obs, exp_q.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      a_seed = 32'h0; b_seed = 32'h0; c_seed = 32'h0;
      a_seed_valid = 1'b0; b_seed_valid = 1'b0; c_seed_valid = 1'b0;
      a_rnd_ready = 1'b0; b_rnd_ready = 1'b0; c_rnd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) ma[k] = m_seed(RST_SEED, k);
      for (int k = 0; k < 2; k++) mb[k] = m_seed(RST_SEED, k);
      mc = m_seed(RST_SEED, 0);

      // Reset state
      chk("rst_a_valid", a_rnd_valid, 64'd0);
      chk("rst_a_sready", a_seed_ready, 64'd1);
      chk("rst_c_valid", c_rnd_valid, 64'd0);
      chk("rst_b_lockup", b_lockup, 64'd0);
      chk("rst_b_rnd", b_rnd, b_word());
      chk("rst_b_ch0", b_rnd[31:0], 64'hACE1_ACE1);
      chk("rst_a_rnd", a_rnd, a_word());

      // Legacy compatibility on the 8-bit instance
      a_seed = 32'hAAAA_AAAA; a_seed_valid = 1'b1;
      for (int k = 0; k < 4; k++) ma[k] = m_seed(a_seed, k);
      push("a_legacy", a_word());
      tick();
      a_seed_valid = 1'b0;
      pop_cmp(a_rnd);
      chk("a_legacy_lo", a_rnd[15:0], 64'h55AA);
      chk("a_legacy_valid", a_rnd_valid, 64'd1);

      // Single step on the 32-bit instance
      b_seed = 32'hAAAA_AAAA; b_seed_valid = 1'b1;
      for (int k = 0; k < 2; k++) mb[k] = m_seed(b_seed, k);
      push("b_seed_load", b_word());
      tick();
      b_seed_valid = 1'b0;
      pop_cmp(b_rnd);
      b_rnd_ready = 1'b1;
      for (int k = 0; k < 2; k++) mb[k] = m_step(mb[k]);
      push("b_step", b_word());
      tick();
      b_rnd_ready = 1'b0;
      pop_cmp(b_rnd);
      chk("b_step_const", b_rnd, 64'hAAAA_AAAA_D555_5555);

      // Backpressure: no accept for 10 cycles
      for (int i = 0; i < 10; i++) begin
         push("b_hold", b_word());
         tick();
         pop_cmp(b_rnd);
      end
      chk("b_hold_valid", b_rnd_valid, 64'd1);

      // Seed accept and rnd accept on the same edge: load wins
      b_rnd_ready = 1'b1;
      b_seed = 32'h1234_5678; b_seed_valid = 1'b1;
      chk("b_preload_word", b_rnd, b_word());
      for (int k = 0; k < 2; k++) mb[k] = m_seed(b_seed, k);
      push("b_collision", b_word());
      tick();
      b_seed_valid = 1'b0; b_rnd_ready = 1'b0;
      pop_cmp(b_rnd);

      // Random consumer readiness
      for (int i = 0; i < 40; i++) begin
         b_rnd_ready = 1'($urandom_range(0, 1));
         if (b_rnd_ready) for (int k = 0; k < 2; k++) mb[k] = m_step(mb[k]);
         push("b_rand_ready", b_word());
         tick();
         pop_cmp(b_rnd);
      end
      b_rnd_ready = 1'b0;

      // Warm-up: three discarded steps; a seed offered meanwhile must wait
      c_seed = 32'hAAAA_AAAA; c_seed_valid = 1'b1;
      mc = m_seed(c_seed, 0);
      tick();
      c_seed = 32'h0F0F_0F0F;
      for (int i = 0; i < 3; i++) begin
         chk("c_warm_valid", c_rnd_valid, 64'd0);
         chk("c_warm_sready", c_seed_ready, 64'd0);
         mc = m_step(mc);
         if (i == 1) c_seed_valid = 1'b0;
         tick();
      end
      chk("c_run_valid", c_rnd_valid, 64'd1);
      chk("c_run_const", c_rnd, 64'h3555_5555);
      chk("c_run_model", c_rnd, {32'h0, mc});
      c_rnd_ready = 1'b1;
      mc = m_step(mc);
      push("c_step", {32'h0, mc});
      tick();
      c_rnd_ready = 1'b0;
      pop_cmp(c_rnd);

      // Zero seed
      b_seed = 32'h0; b_seed_valid = 1'b1;
      for (int k = 0; k < 2; k++) mb[k] = m_seed(b_seed, k);
      push("b_zero_load", b_word());
      tick();
      b_seed_valid = 1'b0;
      pop_cmp(b_rnd);
      chk("b_zero_ch0", b_rnd[31:0], {63'd0, GUARD});
      chk("b_zero_lockup", b_lockup, {63'd0, GUARD});
      b_rnd_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         for (int k = 0; k < 2; k++) mb[k] = m_step(mb[k]);
         push("b_zero_run", b_word());
         tick();
         pop_cmp(b_rnd);
      end
      b_rnd_ready = 1'b0;
      chk("b_zero_lockup_sticky", b_lockup, {63'd0, GUARD});
      b_seed = 32'hC0FF_EE11; b_seed_valid = 1'b1;
      for (int k = 0; k < 2; k++) mb[k] = m_seed(b_seed, k);
      push("b_reseed", b_word());
      tick();
      b_seed_valid = 1'b0;
      pop_cmp(b_rnd);
      chk("b_lockup_clear", b_lockup, 64'd0);

      // Distribution over the 4-channel 8-bit instance
      for (int d = 0; d < 10; d++) begin
         hist[d] = 0;
         bin_size[d] = 0;
      end
      for (int v = 0; v < 256; v++) bin_size[(v * 10) / 256]++;
      a_rnd_ready = 1'b1;
      for (int i = 0; i < DIST_N; i++) begin
         for (int k = 0; k < 4; k++) hist[(int'(a_rnd[k*8 +: 8]) * 10) / 256]++;
         for (int k = 0; k < 4; k++) ma[k] = m_step(ma[k]);
         push("a_run", a_word());
         tick();
         pop_cmp(a_rnd);
      end
      for (int d = 0; d < 10; d++) begin
         real total, expc, dev;
         total = real'(DIST_N * 4);
         expc  = total * real'(bin_size[d]) / 256.0;
         dev   = (real'(hist[d]) > expc) ? real'(hist[d]) - expc : expc - real'(hist[d]);
         checks++;
         assert (dev <= total * 0.005)
         else begin
            failures++;
            $error("FAIL decile_%0d observed=%0d expected=%0.1f+-%0.1f", d, hist[d], expc, total * 0.005);
         end
      end

      // Asynchronous reset in the middle of a run
      #3 reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) ma[k] = m_seed(RST_SEED, k);
      chk("midrst_a_valid", a_rnd_valid, 64'd0);
      chk("midrst_a_sready", a_seed_ready, 64'd1);
      chk("midrst_a_rnd", a_rnd, a_word());
      chk("midrst_b_valid", b_rnd_valid, 64'd0);
      a_rnd_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("postrst_a_valid", a_rnd_valid, 64'd0);
      chk("sb_drained", exp_q.size(), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
